// File: rtl/arm_ctrl_pkg.sv
// Shared encodings for the ARM single-cycle control unit:
// op/cmd fields, condition codes, ALU controls, extend/register selects, flags.
package arm_ctrl_pkg;

    typedef enum logic [1:0] {
        OP_DP  = 2'b00,
        OP_MEM = 2'b01,
        OP_BR  = 2'b10,
        OP_ILL = 2'b11
    } op_t;

    localparam logic [3:0] CMD_AND = 4'b0000;
    localparam logic [3:0] CMD_EOR = 4'b0001;
    localparam logic [3:0] CMD_SUB = 4'b0010;
    localparam logic [3:0] CMD_ADD = 4'b0100;
    localparam logic [3:0] CMD_CMP = 4'b1010;
    localparam logic [3:0] CMD_ORR = 4'b1100;

    typedef enum logic [3:0] {
        COND_EQ = 4'h0, COND_NE = 4'h1, COND_CS = 4'h2, COND_CC = 4'h3,
        COND_MI = 4'h4, COND_PL = 4'h5, COND_VS = 4'h6, COND_VC = 4'h7,
        COND_HI = 4'h8, COND_LS = 4'h9, COND_GE = 4'ha, COND_LT = 4'hb,
        COND_GT = 4'hc, COND_LE = 4'hd, COND_AL = 4'he, COND_NV = 4'hf
    } cond_t;

    localparam logic [2:0] ALU_ADD = 3'b000;
    localparam logic [2:0] ALU_SUB = 3'b001;
    localparam logic [2:0] ALU_AND = 3'b010;
    localparam logic [2:0] ALU_ORR = 3'b011;
    localparam logic [2:0] ALU_EOR = 3'b100;

    localparam logic [1:0] IMM_DP  = 2'b00;
    localparam logic [1:0] IMM_MEM = 2'b01;
    localparam logic [1:0] IMM_BR  = 2'b10;

    localparam logic [1:0] REG_DP  = 2'b00;
    localparam logic [1:0] REG_BR  = 2'b01;
    localparam logic [1:0] REG_STR = 2'b10;

    typedef struct packed {
        logic n;
        logic z;
        logic c;
        logic v;
    } flags_t;

endpackage

// File: rtl/arm_controller_cond_unit.sv
// NZCV flag register, condition evaluation and gating of state-changing strobes.
module cond_unit
    import arm_ctrl_pkg::*;
(
    input  logic       clk,
    input  logic       reset,
    input  logic [3:0] cond,
    input  logic [3:0] ALUFlags,
    input  logic       flag_wr_nz,
    input  logic       flag_wr_cv,
    input  logic       reg_w,
    input  logic       mem_w,
    input  logic       pcs,
    output logic       RegWrite,
    output logic       MemWrite,
    output logic       PCSrc,
    output logic       cond_ex
);

    flags_t flags;

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            flags <= '0;
        end else if (cond_ex) begin
            if (flag_wr_nz) begin
                flags.n <= ALUFlags[3];
                flags.z <= ALUFlags[2];
            end
            if (flag_wr_cv) begin
                flags.c <= ALUFlags[1];
                flags.v <= ALUFlags[0];
            end
        end
    end

    always_comb begin
        cond_ex = 1'b0;
        case (cond_t'(cond))
            COND_EQ: cond_ex = flags.z;
            COND_NE: cond_ex = !flags.z;
            COND_CS: cond_ex = flags.c;
            COND_CC: cond_ex = !flags.c;
            COND_MI: cond_ex = flags.n;
            COND_PL: cond_ex = !flags.n;
            COND_VS: cond_ex = flags.v;
            COND_VC: cond_ex = !flags.v;
            COND_HI: cond_ex = flags.c && !flags.z;
            COND_LS: cond_ex = !flags.c || flags.z;
            COND_GE: cond_ex = flags.n == flags.v;
            COND_LT: cond_ex = flags.n != flags.v;
            COND_GT: cond_ex = !flags.z && (flags.n == flags.v);
            COND_LE: cond_ex = flags.z || (flags.n != flags.v);
            COND_AL: cond_ex = 1'b1;
            default: cond_ex = 1'b0;
        endcase
    end

    assign RegWrite = reg_w & cond_ex;
    assign MemWrite = mem_w & cond_ex;
    assign PCSrc    = pcs & cond_ex;

endmodule

// File: rtl/arm_controller.sv
// ARM single-cycle control unit: main decode plus conditional execution.
// Optional perf counters enabled by defining CTRL_PERF_CNT_EN.
module arm_controller
    import arm_ctrl_pkg::*;
(
    input  logic        clk,
    input  logic        reset,
    input  logic [19:0] Instr,
    input  logic [3:0]  ALUFlags,
    output logic [1:0]  RegSrc,
    output logic        RegWrite,
    output logic [1:0]  ImmSrc,
    output logic        ALUSrc,
    output logic [2:0]  ALUControl,
    output logic        MemtoReg,
    output logic        MemWrite,
    output logic        PCSrc
`ifdef CTRL_PERF_CNT_EN
    ,
    output logic [31:0] InstrCount,
    output logic [31:0] SkipCount
`endif
);

    logic [3:0] cond;
    logic [1:0] op;
    logic [3:0] cmd;
    logic [3:0] rd;
    logic       s_bit;
    logic       legal;
    logic       reg_w;
    logic       mem_w;
    logic       branch;
    logic       pcs;
    logic       flag_wr_nz;
    logic       flag_wr_cv;
    logic       cond_ex;

    assign cond  = Instr[19:16];
    assign op    = Instr[15:14];
    assign cmd   = Instr[12:9];
    assign s_bit = Instr[8];
    assign rd    = Instr[3:0];

    always_comb begin
        RegSrc     = REG_DP;
        ImmSrc     = IMM_DP;
        ALUSrc     = 1'b0;
        ALUControl = ALU_ADD;
        MemtoReg   = 1'b0;
        legal      = 1'b0;
        reg_w      = 1'b0;
        mem_w      = 1'b0;
        branch     = 1'b0;
        flag_wr_nz = 1'b0;
        flag_wr_cv = 1'b0;
        case (op_t'(op))
            OP_DP: begin
                ALUSrc = Instr[13];
                legal  = 1'b1;
                reg_w  = 1'b1;
                case (cmd)
                    CMD_AND: ALUControl = ALU_AND;
                    CMD_EOR: ALUControl = ALU_EOR;
                    CMD_SUB: ALUControl = ALU_SUB;
                    CMD_ADD: ALUControl = ALU_ADD;
                    CMD_ORR: ALUControl = ALU_ORR;
                    CMD_CMP: begin
                        ALUControl = ALU_SUB;
                        reg_w      = 1'b0;
                    end
                    default: begin
                        legal = 1'b0;
                        reg_w = 1'b0;
                    end
                endcase
                flag_wr_nz = legal & s_bit;
                flag_wr_cv = legal & s_bit &
                             ((cmd == CMD_ADD) || (cmd == CMD_SUB) ||
                              (cmd == CMD_CMP));
            end
            OP_MEM: begin
                ImmSrc     = IMM_MEM;
                ALUSrc     = 1'b1;
                ALUControl = Instr[11] ? ALU_ADD : ALU_SUB;
                legal      = 1'b1;
                if (Instr[8]) begin
                    MemtoReg = 1'b1;
                    reg_w    = 1'b1;
                end else begin
                    mem_w  = 1'b1;
                    RegSrc = REG_STR;
                end
            end
            OP_BR: begin
                ImmSrc = IMM_BR;
                RegSrc = REG_BR;
                ALUSrc = 1'b1;
                legal  = 1'b1;
                branch = 1'b1;
            end
            default: legal = 1'b0;
        endcase
    end

    // Writes to R15 redirect the PC just like a branch
    assign pcs = branch | (reg_w & (rd == 4'hf));

    cond_unit u_cond (
        .clk        (clk),
        .reset      (reset),
        .cond       (cond),
        .ALUFlags   (ALUFlags),
        .flag_wr_nz (flag_wr_nz),
        .flag_wr_cv (flag_wr_cv),
        .reg_w      (reg_w),
        .mem_w      (mem_w),
        .pcs        (pcs),
        .RegWrite   (RegWrite),
        .MemWrite   (MemWrite),
        .PCSrc      (PCSrc),
        .cond_ex    (cond_ex)
    );

`ifdef CTRL_PERF_CNT_EN
    logic unused_bits;
    assign unused_bits = ^Instr[7:4];

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            InstrCount <= '0;
            SkipCount  <= '0;
        end else begin
            InstrCount <= InstrCount + 32'd1;
            if (legal && !cond_ex)
                SkipCount <= SkipCount + 32'd1;
        end
    end
`else
    logic unused_bits;
    assign unused_bits = ^{Instr[7:4], legal, cond_ex};
`endif

endmodule

// File: tb/tb_arm_controller.sv
// Self-checking bench for arm_controller: directed vector table plus
// hand-written reset and perf-counter sequences.
module tb_arm_controller;

    logic        clk;
    logic        reset;
    logic [19:0] instr;
    logic [3:0]  alu_flags;
    logic [1:0]  reg_src;
    logic        reg_write;
    logic [1:0]  imm_src;
    logic        alu_src;
    logic [2:0]  alu_control;
    logic        mem_to_reg;
    logic        mem_write;
    logic        pc_src;
`ifdef CTRL_PERF_CNT_EN
    logic [31:0] instr_count;
    logic [31:0] skip_count;
`endif

    int checks = 0;
    int errors = 0;

    arm_controller dut (
        .clk        (clk),
        .reset      (reset),
        .Instr      (instr),
        .ALUFlags   (alu_flags),
        .RegSrc     (reg_src),
        .RegWrite   (reg_write),
        .ImmSrc     (imm_src),
        .ALUSrc     (alu_src),
        .ALUControl (alu_control),
        .MemtoReg   (mem_to_reg),
        .MemWrite   (mem_write),
        .PCSrc      (pc_src)
`ifdef CTRL_PERF_CNT_EN
        ,
        .InstrCount (instr_count),
        .SkipCount  (skip_count)
`endif
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        logic [19:0] instr;
        logic [3:0]  af;
        logic [1:0]  rs;
        logic        rw;
        logic [1:0]  is;
        logic        as;
        logic [2:0]  ac;
        logic        m2r;
        logic        mw;
        logic        pc;
        logic [3:0]  fl;
    } vec_t;

    vec_t vecs[17];

    task automatic check(input string name, input logic [31:0] act,
                         input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    function automatic logic [3:0] cur_flags();
        return dut.u_cond.flags;
    endfunction

    initial begin
        //          instr     af    rs    rw    is    as    ac      m2r   mw    pc    flags
        vecs[0]  = '{20'hE0855, 4'hF, 2'b00, 1'b1, 2'b00, 1'b0, 3'b000, 1'b0, 1'b0, 1'b0, 4'h0};
        vecs[1]  = '{20'hE1550, 4'h4, 2'b00, 1'b0, 2'b00, 1'b0, 3'b001, 1'b0, 1'b0, 1'b0, 4'h4};
        vecs[2]  = '{20'h0A000, 4'h0, 2'b01, 1'b0, 2'b10, 1'b1, 3'b000, 1'b0, 1'b0, 1'b1, 4'h4};
        vecs[3]  = '{20'h1A000, 4'h0, 2'b01, 1'b0, 2'b10, 1'b1, 3'b000, 1'b0, 1'b0, 1'b0, 4'h4};
        vecs[4]  = '{20'hE5912, 4'h0, 2'b00, 1'b1, 2'b01, 1'b1, 3'b000, 1'b1, 1'b0, 1'b0, 4'h4};
        vecs[5]  = '{20'hE5812, 4'h0, 2'b10, 1'b0, 2'b01, 1'b1, 3'b000, 1'b0, 1'b1, 1'b0, 4'h4};
        vecs[6]  = '{20'h10955, 4'hB, 2'b00, 1'b0, 2'b00, 1'b0, 3'b000, 1'b0, 1'b0, 1'b0, 4'h4};
        vecs[7]  = '{20'hE1A05, 4'hF, 2'b00, 1'b0, 2'b00, 1'b0, 3'b000, 1'b0, 1'b0, 1'b0, 4'h4};
        vecs[8]  = '{20'hE2555, 4'hA, 2'b00, 1'b1, 2'b00, 1'b1, 3'b001, 1'b0, 1'b0, 1'b0, 4'hA};
        vecs[9]  = '{20'hE0155, 4'h5, 2'b00, 1'b1, 2'b00, 1'b0, 3'b010, 1'b0, 1'b0, 1'b0, 4'h6};
        vecs[10] = '{20'hE180F, 4'hF, 2'b00, 1'b1, 2'b00, 1'b0, 3'b011, 1'b0, 1'b0, 1'b1, 4'h6};
        vecs[11] = '{20'h20231, 4'h0, 2'b00, 1'b1, 2'b00, 1'b0, 3'b100, 1'b0, 1'b0, 1'b0, 4'h6};
        vecs[12] = '{20'h95112, 4'h0, 2'b00, 1'b1, 2'b01, 1'b1, 3'b001, 1'b1, 1'b0, 1'b0, 4'h6};
        vecs[13] = '{20'hF0855, 4'h0, 2'b00, 1'b0, 2'b00, 1'b0, 3'b000, 1'b0, 1'b0, 1'b0, 4'h6};
        vecs[14] = '{20'hEC000, 4'h0, 2'b00, 1'b0, 2'b00, 1'b0, 3'b000, 1'b0, 1'b0, 1'b0, 4'h6};
        vecs[15] = '{20'hE591F, 4'h0, 2'b00, 1'b1, 2'b01, 1'b1, 3'b000, 1'b1, 1'b0, 1'b1, 4'h6};
        vecs[16] = '{20'hB0855, 4'h0, 2'b00, 1'b0, 2'b00, 1'b0, 3'b000, 1'b0, 1'b0, 1'b0, 4'h6};

        reset     = 1'b0;
        instr     = 20'h0A000;
        alu_flags = 4'h0;
        #2;
        check("rst_flags", {28'b0, cur_flags()}, 32'h0);
        check("rst_beq_pcsrc", {31'b0, pc_src}, 32'h0);
`ifdef CTRL_PERF_CNT_EN
        check("rst_icount", instr_count, 32'h0);
        check("rst_scount", skip_count, 32'h0);
`endif
        @(negedge clk);
        reset = 1'b1;

        for (int i = 0; i < 17; i++) begin
            @(negedge clk);
            instr     = vecs[i].instr;
            alu_flags = vecs[i].af;
            #1;
            check($sformatf("v%0d_regsrc", i), {30'b0, reg_src}, {30'b0, vecs[i].rs});
            check($sformatf("v%0d_regwrite", i), {31'b0, reg_write}, {31'b0, vecs[i].rw});
            check($sformatf("v%0d_immsrc", i), {30'b0, imm_src}, {30'b0, vecs[i].is});
            check($sformatf("v%0d_alusrc", i), {31'b0, alu_src}, {31'b0, vecs[i].as});
            check($sformatf("v%0d_aluctl", i), {29'b0, alu_control}, {29'b0, vecs[i].ac});
            check($sformatf("v%0d_memtoreg", i), {31'b0, mem_to_reg}, {31'b0, vecs[i].m2r});
            check($sformatf("v%0d_memwrite", i), {31'b0, mem_write}, {31'b0, vecs[i].mw});
            check($sformatf("v%0d_pcsrc", i), {31'b0, pc_src}, {31'b0, vecs[i].pc});
            @(posedge clk);
            #1;
            check($sformatf("v%0d_flags", i), {28'b0, cur_flags()}, {28'b0, vecs[i].fl});
        end

        // Async reset between edges, and a flag update discarded while held
        @(negedge clk);
        instr     = 20'hE1550;
        alu_flags = 4'h4;
        @(posedge clk);
        #1;
        check("pre_rst_flags", {28'b0, cur_flags()}, 32'h4);
        instr = 20'h0A000;
        #1;
        check("pre_rst_beq", {31'b0, pc_src}, 32'h1);
        #2;
        reset = 1'b0;
        #1;
        check("mid_rst_flags", {28'b0, cur_flags()}, 32'h0);
        check("mid_rst_beq", {31'b0, pc_src}, 32'h0);
`ifdef CTRL_PERF_CNT_EN
        check("mid_rst_icount", instr_count, 32'h0);
        check("mid_rst_scount", skip_count, 32'h0);
`endif
        instr     = 20'hE1550;
        alu_flags = 4'hF;
        @(posedge clk);
        #1;
        check("held_rst_flags", {28'b0, cur_flags()}, 32'h0);
        @(negedge clk);
        reset = 1'b1;

`ifdef CTRL_PERF_CNT_EN
        begin
            logic [19:0] seq [5];
            seq[0] = 20'hE0855;
            seq[1] = 20'h0A000;
            seq[2] = 20'hE0855;
            seq[3] = 20'h0A000;
            seq[4] = 20'hE0855;
            alu_flags = 4'h0;
            for (int i = 0; i < 5; i++) begin
                instr = seq[i];
                @(posedge clk);
                #1;
            end
            check("perf_icount", instr_count, 32'd5);
            check("perf_scount", skip_count, 32'd2);
            @(negedge clk);
            force dut.InstrCount = 32'hFFFF_FFFF;
            #1;
            release dut.InstrCount;
            @(posedge clk);
            #1;
            check("perf_wrap", instr_count, 32'h0);
        end
`endif

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
